div_ctrl: RTL and testbench
===========================

# div_ctrl

Multi-cycle divide sequencer attached to the EX stage. It accepts a DIV/DIVU request from EX, runs a radix-2 restoring division one quotient bit per cycle, and requests a pipeline stall until the result is ready. It returns quotient and remainder as a {HI, LO} pair for the HI/LO write path. A divisor of zero is short-circuited to a zero result.

## Interface
- DATA_WIDTH, 32, operand width; result is 2*DATA_WIDTH.
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset; 0 forces the reset state immediately.
- start_i  in  1  divide request from EX; held high until ready_o is seen.
- annul_i  in  1  cancel the request (flush or exception); overrides start_i.
- signed_i  in  1  1 = DIV (two's complement), 0 = DIVU; sampled at acceptance only.
- dividend_i  in  DATA_WIDTH  dividend; sampled at acceptance only.
- divisor_i  in  DATA_WIDTH  divisor; sampled at acceptance only.
- result_o  out  2*DATA_WIDTH  {remainder (HI), quotient (LO)}; registered.
- ready_o  out  1  result valid; registered.
- stall_req_o  out  1  combinational stall request to the pipeline controller.

## Operation
- States: IDLE, DIV_ZERO, BUSY, DONE.
- Reset: state IDLE, result_o 0, ready_o 0, counter 0, internal registers 0.
- IDLE, start_i=1 and annul_i=0:
  - divisor_i==0 -> DIV_ZERO.
  - Otherwise -> BUSY.
  - On acceptance, latch the sign flags and the absolute values (signed_i=1), or the raw values (signed_i=0). Clear counter to 0.
- IDLE, otherwise: stay in IDLE.
- DIV_ZERO: next edge -> DONE, result_o 0, ready_o 1.
- BUSY, one restoring step per edge:
  - partial remainder = {rem[DATA_WIDTH-2:0], next dividend MSB} - divisor.
  - Non-negative: keep the difference and shift in quotient bit 1. Negative: keep the unshifted-minuend value and shift in 0.
  - Counter increments each step.
- BUSY, final step (counter==DATA_WIDTH-1):
  - Apply signs, load result_o and set ready_o=1, then -> DONE.
  - Quotient is negated if signed_i=1 and the operand signs differ.
  - Remainder takes the dividend's sign.
- BUSY, annul_i=1: -> IDLE on the next edge, counter cleared, ready_o stays 0. annul_i takes priority over completion on the same edge.
- DONE, start_i=1: stay in DONE with result_o and ready_o held.
- DONE, start_i=0 or annul_i=1: -> IDLE, ready_o 0, result_o 0.
- stall_req_o = start_i & ~annul_i & (state != DONE).
- Arithmetic:
  - Absolute value uses modulo-2^DATA_WIDTH negation, so 0x80000000 maps to unsigned 0x80000000.
  - Signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0 (wraps, no trap).
  - Inputs changing while BUSY have no effect.

## Timing
- Edge E0 accepts the request (IDLE->BUSY). Steps run on E1..E32; DONE is entered on E32.
- ready_o is high 32 cycles after the acceptance edge, i.e. 33 cycles of stall including the request cycle.
- Divide by zero: E0 -> DIV_ZERO, E1 -> DONE; ready_o is high after 2 edges.
- ready_o and result_o change only on clock edges or on reset.
- Back-to-back requests need start_i low for at least one cycle (DONE->IDLE) between operations.
- Reset asserted mid-operation: immediate IDLE, outputs 0, no partial result. stall_req_o then follows start_i.

## Test plan
- DIVU 100/7 -> after 32 edges past acceptance, ready_o=1 and result_o={0x00000002, 0x0000000E}. stall_req_o is high exactly while start_i is high before DONE.
- DIV -7/2 -> result_o={0xFFFFFFFF, 0xFFFFFFFD}. DIV 7/-2 -> {0x00000001, 0xFFFFFFFD}.
- DIVU 5/0 -> DIV_ZERO then DONE; ready_o=1 after 2 edges, result_o=0.
- DIV 0x80000000/0xFFFFFFFF -> {0x00000000, 0x80000000}. DIVU 0xFFFFFFFF/1 -> {0, 0xFFFFFFFF}.
- annul_i pulsed at the 10th BUSY cycle -> IDLE on the next edge; ready_o never rises; a new DIVU 9/3 afterwards yields {0, 3}.
- rst driven low at the 20th BUSY cycle -> state IDLE and outputs 0 immediately. start_i held high in DONE -> result held; start_i low -> IDLE and outputs 0 the next edge.

Source files
------------

// File: rtl/div_ctrl.sv
// Radix-2 restoring divide sequencer: one quotient bit per edge, result {rem, quo} 32 edges after acceptance (2 for /0).
// Stalls EX while a request is pending and not yet DONE; the result is held while start_i stays high in DONE.
module div_ctrl #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_i,
  input  logic                    annul_i,
  input  logic                    signed_i,
  input  logic [DATA_WIDTH-1:0]   dividend_i,
  input  logic [DATA_WIDTH-1:0]   divisor_i,
  output logic [2*DATA_WIDTH-1:0] result_o,
  output logic                    ready_o,
  output logic                    stall_req_o
);

  localparam int                CW   = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0]     LAST = CW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, DIV_ZERO, BUSY, DONE} state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   rem_q, rem_d;
  logic [DATA_WIDTH-1:0]   dvd_q, dvd_d;
  logic [DATA_WIDTH-1:0]   dvs_q, dvs_d;
  logic                    neg_quo_q, neg_quo_d;
  logic                    neg_rem_q, neg_rem_d;
  logic [2*DATA_WIDTH-1:0] result_q, result_d;
  logic                    ready_q, ready_d;

  logic [DATA_WIDTH-1:0]   minuend;
  logic [DATA_WIDTH:0]     diff;
  logic                    qbit;
  logic [DATA_WIDTH-1:0]   rem_step, quo_step;
  logic [DATA_WIDTH-1:0]   abs_dvd, abs_dvs;

  // Dividend register doubles as the quotient shift register: dividend bits leave at the top as quotient bits enter at the bottom.
  always_comb begin
    minuend  = {rem_q[DATA_WIDTH-2:0], dvd_q[DATA_WIDTH-1]};
    diff     = {1'b0, minuend} - {1'b0, dvs_q};
    qbit     = ~diff[DATA_WIDTH];
    rem_step = qbit ? diff[DATA_WIDTH-1:0] : minuend;
    quo_step = {dvd_q[DATA_WIDTH-2:0], qbit};
    abs_dvd  = (signed_i && dividend_i[DATA_WIDTH-1]) ? -dividend_i : dividend_i;
    abs_dvs  = (signed_i && divisor_i[DATA_WIDTH-1])  ? -divisor_i  : divisor_i;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;
    ready_d   = ready_q;
    case (state_q)
      IDLE: begin
        if (start_i && !annul_i) begin
          neg_quo_d = signed_i && (dividend_i[DATA_WIDTH-1] ^ divisor_i[DATA_WIDTH-1]);
          neg_rem_d = signed_i && dividend_i[DATA_WIDTH-1];
          dvd_d     = abs_dvd;
          dvs_d     = abs_dvs;
          rem_d     = '0;
          cnt_d     = '0;
          state_d   = (divisor_i == '0) ? DIV_ZERO : BUSY;
        end
      end
      DIV_ZERO: begin
        result_d = '0;
        ready_d  = 1'b1;
        state_d  = DONE;
      end
      BUSY: begin
        if (annul_i) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          rem_d = rem_step;
          dvd_d = quo_step;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            result_d = {neg_rem_q ? -rem_step : rem_step,
                        neg_quo_q ? -quo_step : quo_step};
            ready_d  = 1'b1;
            state_d  = DONE;
          end
        end
      end
      DONE: begin
        if (!start_i || annul_i) begin
          result_d = '0;
          ready_d  = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
    end
  end

  assign result_o    = result_q;
  assign ready_o     = ready_q;
  assign stall_req_o = start_i && !annul_i && (state_q != DONE);

endmodule

// File: tb/tb_div_ctrl.sv
// Bench for div_ctrl: vector table plus hand-written annul/reset/hold sequences, scoreboard-checked.
module tb_div_ctrl;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic           start_i, annul_i, signed_i;
  logic [W-1:0]   dividend_i, divisor_i;
  logic [2*W-1:0] result_o;
  logic           ready_o, stall_req_o;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic           sgn;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] res;
    int             hold;
  } vec_t;

  typedef struct {
    logic [2*W-1:0] res;
    int             lat;
  } exp_t;

  exp_t sb[$];
  vec_t tv[$];

  div_ctrl #(.DATA_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .annul_i(annul_i), .signed_i(signed_i),
    .dividend_i(dividend_i), .divisor_i(divisor_i), .result_o(result_o),
    .ready_o(ready_o), .stall_req_o(stall_req_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference arithmetic: truncating division on magnitudes, then signs applied.
  function automatic logic [2*W-1:0] model(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
    logic na, nb;
    logic [W-1:0] ua, ub, q, r;
    if (b == '0) return '0;
    na = sgn & a[W-1];
    nb = sgn & b[W-1];
    ua = na ? (~a + 32'd1) : a;
    ub = nb ? (~b + 32'd1) : b;
    q  = ua / ub;
    r  = ua % ub;
    if (na ^ nb) q = ~q + 32'd1;
    if (na)      r = ~r + 32'd1;
    return {r, q};
  endfunction

  task automatic run_op(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2*W-1:0] exp_res, input int hold, input string tag);
    exp_t e;
    int   n;
    bit   got;
    bit   stall_ok;
    @(negedge clk);
    start_i = 1'b1; annul_i = 1'b0; signed_i = sgn; dividend_i = a; divisor_i = b;
    e.res = exp_res;
    e.lat = (b == '0) ? 2 : 33;
    sb.push_back(e);
    #1 chk({tag, "_stall_req"}, 64'(stall_req_o), 64'd1);
    n = 0; got = 0; stall_ok = 1;
    while (n < 100 && !got) begin
      @(posedge clk);
      #1 n++;
      if (ready_o) got = 1;
      else if (stall_req_o !== 1'b1) stall_ok = 0;
      // operands are don't-care once accepted
      dividend_i = $urandom; divisor_i = $urandom; signed_i = ~sgn;
    end
    chk({tag, "_ready_timeout"}, 64'(got), 64'd1);
    chk({tag, "_stall_while_busy"}, 64'(stall_ok), 64'd1);
    e = sb.pop_front();
    if (got) begin
      chk({tag, "_result"}, result_o, e.res);
      chk({tag, "_latency"}, 64'(n), 64'(e.lat));
      chk({tag, "_stall_in_done"}, 64'(stall_req_o), 64'd0);
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1 chk({tag, "_hold_ready"}, 64'(ready_o), 64'd1);
      chk({tag, "_hold_result"}, result_o, e.res);
    end
    @(negedge clk);
    start_i = 1'b0;
    @(posedge clk);
    #1 chk({tag, "_release_ready"}, 64'(ready_o), 64'd0);
    chk({tag, "_release_result"}, result_o, 64'd0);
  endtask

  initial begin
    rst = 1'b0; start_i = 1'b0; annul_i = 1'b0; signed_i = 1'b0;
    dividend_i = '0; divisor_i = '0;
    #1;
    chk("reset_ready", 64'(ready_o), 64'd0);
    chk("reset_result", result_o, 64'd0);
    chk("reset_stall", 64'(stall_req_o), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    tv.push_back('{1'b0, 32'd100,        32'd7,          {32'h00000002, 32'h0000000E}, 3});
    tv.push_back('{1'b1, 32'hFFFFFFF9,   32'd2,          {32'hFFFFFFFF, 32'hFFFFFFFD}, 0});
    tv.push_back('{1'b1, 32'd7,          32'hFFFFFFFE,   {32'h00000001, 32'hFFFFFFFD}, 0});
    tv.push_back('{1'b0, 32'd5,          32'd0,          64'd0,                        2});
    tv.push_back('{1'b1, 32'h80000000,   32'hFFFFFFFF,   {32'h00000000, 32'h80000000}, 0});
    tv.push_back('{1'b0, 32'hFFFFFFFF,   32'd1,          {32'h00000000, 32'hFFFFFFFF}, 0});
    tv.push_back('{1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9,   {32'hFFFFFFFE, 32'h0000000E}, 0});
    tv.push_back('{1'b0, 32'hFFFFFFFF,   32'hFFFFFFFE,   {32'h00000001, 32'h00000001}, 0});
    tv.push_back('{1'b1, 32'h12345678,   32'd0,          64'd0,                        0});
    tv.push_back('{1'b0, 32'h80000000,   32'h80000000,   {32'h00000000, 32'h00000001}, 0});
    for (int i = 0; i < 4; i++) begin
      logic         s;
      logic [W-1:0] a, b;
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      b = $urandom >> $urandom_range(0, 28);
      if (b == '0) b = 32'd3;
      tv.push_back('{s, a, b, model(s, a, b), 0});
    end

    foreach (tv[i]) run_op(tv[i].sgn, tv[i].a, tv[i].b, tv[i].res, tv[i].hold, $sformatf("vec%0d", i));

    // Annul mid-operation: no result may appear; the next request starts clean.
    begin
      bit quiet;
      @(negedge clk);
      start_i = 1'b1; signed_i = 1'b0; dividend_i = 32'd1000; divisor_i = 32'd7;
      repeat (11) @(posedge clk);
      @(negedge clk);
      annul_i = 1'b1;
      #1 chk("annul_stall_drop", 64'(stall_req_o), 64'd0);
      @(negedge clk);
      start_i = 1'b0; annul_i = 1'b0;
      quiet = 1;
      repeat (40) begin
        @(posedge clk);
        #1 if (ready_o !== 1'b0 || result_o !== '0) quiet = 0;
      end
      chk("annul_no_ready", 64'(quiet), 64'd1);
      run_op(1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 0, "after_annul");
    end

    // Asynchronous reset mid-operation.
    @(negedge clk);
    start_i = 1'b1; signed_i = 1'b0; dividend_i = 32'hFFFFFFFF; divisor_i = 32'd1;
    repeat (21) @(posedge clk);
    #2 rst = 1'b0;
    #1 chk("rst_mid_ready", 64'(ready_o), 64'd0);
    chk("rst_mid_result", result_o, 64'd0);
    chk("rst_mid_stall_follows_start", 64'(stall_req_o), 64'd1);
    start_i = 1'b0;
    #1 chk("rst_mid_stall_low", 64'(stall_req_o), 64'd0);
    repeat (2) @(posedge clk);
    #1 chk("rst_hold_ready", 64'(ready_o), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    run_op(1'b1, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD}, 1, "after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
